pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter generator for the fetch stage: holds the current PC,
//  issues it to instruction fetch via a valid/ready handshake, and advances or
//  redirects it under trap, branch, stall and halt control. Sits between the
//  branch/trap resolution logic and the instruction-memory request port.
// PARAMETERS
//  XLEN       32  PC / address width in bits
//  RESET_VEC  0   PC value loaded on reset (XLEN bits)
//  ALIGN_BITS 2   low PC bits required zero (2: 32-bit insns, 1: compressed)
//  STEP       4   sequential increment added to PC on accepted fetch
//  CNT_W      32  width of accepted-fetch counter
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      reset, asynchronous, active-high
//  fetch_ready  in   1      fetch side accepts current PC this cycle
//  taken_br     in   1      branch/jump redirect request
//  br_tgt_pc    in   XLEN   branch/jump target
//  trap         in   1      trap redirect request (highest priority)
//  trap_vec     in   XLEN   trap handler address
//  halt         in   1      request to stop issuing fetches
//  pc           out  XLEN   current PC (registered)
//  fetch_valid  out  1      pc is a valid fetch request
//  pc_misalign  out  1      one-cycle flag: last branch target had nonzero low bits
//  fetch_cnt    out  CNT_W  number of accepted fetches, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async): pc=RESET_VEC, state=BOOT, pc_misalign=0, fetch_cnt=0, fetch_valid=0.
//  - States: BOOT, RUN, HALT. fetch_valid = (state==RUN), decoded from state only.
//  - BOOT -> RUN unconditionally next cycle (one bubble after reset release).
//  - accept = fetch_valid & fetch_ready. fetch_cnt increments on accept, wraps.
//  - Next pc, priority (any state except BOOT):
//      trap     -> {trap_vec[XLEN-1:ALIGN_BITS], ALIGN_BITS'b0}
//      taken_br -> {br_tgt_pc[XLEN-1:ALIGN_BITS], ALIGN_BITS'b0}
//      accept   -> pc + STEP, modulo 2^XLEN (wrap to 0 allowed, no flag)
//      else     -> pc held
//  - BOOT ignores trap/taken_br; pc stays RESET_VEC.
//  - Redirect while fetch_valid & !fetch_ready: pending request is cancelled, pc
//    replaced, fetch_valid stays 1; this is the only case pc changes while valid is
//    high and unaccepted. Otherwise pc stable while fetch_valid & !fetch_ready.
//  - Redirect and accept same cycle: accepted fetch counts; next pc is the target.
//  - pc_misalign: registered; 1 the cycle after a taken_br (without trap) whose
//    br_tgt_pc[ALIGN_BITS-1:0] != 0; else 0. Trap vector low bits cleared silently.
//  - RUN -> HALT when halt & (accept | trap | taken_br | !fetch_ready is false):
//    i.e. only when halt=1 and the current request is accepted or redirected;
//    with halt=1 and request stalled, stay in RUN holding valid.
//  - HALT: fetch_valid=0, pc held unless trap/taken_br (redirects still load pc).
//    HALT -> RUN when halt=0; first fetch is the held/redirected pc.
//  - Reset mid-operation: immediate return to reset values regardless of state.
// TESTING
//  1 rst pulse, fetch_ready=1 -> cycle0 valid=0 pc=0; then pc 0,4,8,C; fetch_cnt 1,2,3.
//  2 fetch_ready=0 for 3 cycles at pc=8 -> pc held 8, valid=1, fetch_cnt unchanged.
//  3 trap=1 trap_vec=0x100 and taken_br=1 br_tgt_pc=0x40 same cycle -> pc=0x100, misalign=0.
//  4 taken_br=1 br_tgt_pc=0x43 -> next pc=0x40, pc_misalign=1 for exactly one cycle.
//  5 halt=1 with fetch_ready=0 -> stays RUN; fetch_ready=1 -> HALT, valid=0; halt=0 -> valid=1, pc continues.
//  6 pc=0xFFFFFFFC accepted -> pc=0; rst asserted mid-stall -> pc=RESET_VEC, valid=0 immediately.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-side bundle for pc_unit: control/redirect inputs toward the PC generator
// and the registered PC request it issues back.
interface pc_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             fetch_ready;
  logic             taken_br;
  logic [XLEN-1:0]  br_tgt_pc;
  logic             trap;
  logic [XLEN-1:0]  trap_vec;
  logic             halt;
  logic [XLEN-1:0]  pc;
  logic             fetch_valid;
  logic             pc_misalign;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    output fetch_ready, taken_br, br_tgt_pc, trap, trap_vec, halt,
    input  pc, fetch_valid, pc_misalign, fetch_cnt
  );

  modport slave (
    input  fetch_ready, taken_br, br_tgt_pc, trap, trap_vec, halt,
    output pc, fetch_valid, pc_misalign, fetch_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter generator: issues the current PC over a valid/ready handshake
// and advances or redirects it under trap, branch, stall and halt control.
module pc_unit #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_VEC  = '0,
  parameter int               ALIGN_BITS = 2,
  parameter int               STEP       = 4,
  parameter int               CNT_W      = 32
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Mask form keeps ALIGN_BITS=0 legal, where a [ALIGN_BITS-1:0] slice would not be.
  localparam logic [XLEN-1:0] LOW_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetchValid;
  logic             accept;
  logic             redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.halt && (accept || redirect)) state_d = HALT;
      HALT:    if (!bus.halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    fetchValid = (state_q == RUN);
  end

  assign accept   = fetchValid & bus.fetch_ready;
  assign redirect = (state_q != BOOT) & (bus.trap | bus.taken_br);

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    cnt_d      = accept ? cnt_q + CNT_W'(1) : cnt_q;
    if (state_q != BOOT) begin
      if (bus.trap) begin
        pc_d = bus.trap_vec & ~LOW_MASK;
      end else if (bus.taken_br) begin
        pc_d       = bus.br_tgt_pc & ~LOW_MASK;
        misalign_d = |(bus.br_tgt_pc & LOW_MASK);
      end else if (accept) begin
        pc_d = pc_q + XLEN'(STEP);
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetchValid;
  assign bus.pc_misalign = misalign_q;
  assign bus.fetch_cnt   = cnt_q;

endmodule
